// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher
//   Pulls sprite draw commands from the sprite queue and hands each one to an
//   idle sprite_render channel. Commands whose origin lies outside the
//   framebuffer are popped and dropped (culled). A zero scale is forced to 1.
//   Dispatch and cull totals are kept in saturating counters. frame_idle tells
//   the framebuffer swap logic that the queue is drained and every channel is
//   idle.
//
//   Optional feature: define SPRITE_DISPATCH_RR_EN for round-robin channel
//   selection. Without it the lowest-index idle channel wins.
//
// Ports
//   clock, fb_resetting       clock; asynchronous active-high reset
//   q_dequeue                 one-cycle pop strobe to the queue
//   q_is_empty, q_id, q_x,    queue empty flag and head command fields
//   q_y, q_scale
//   ch_en, ch_rst             per-channel enable / renderer reset
//   ch_id, ch_x, ch_y,        packed per-channel command fields,
//   ch_scale                  channel i at [i*W +: W]
//   ch_finished               per-channel finished from the renderers
//   frame_idle                queue empty and all channels idle (registered)
//   dispatch_cnt, cull_cnt    saturating statistics since reset
module sprite_dispatcher #(
  parameter int NUM_CH    = 4,
  parameter int ID_W      = 8,
  parameter int COORD_W   = 10,
  parameter int FB_WIDTH  = 800,
  parameter int FB_HEIGHT = 600,
  parameter int CNT_W     = 16
) (
  input  logic                      clock,
  input  logic                      fb_resetting,
  output logic                      q_dequeue,
  input  logic                      q_is_empty,
  input  logic [7:0]                q_id,
  input  logic [15:0]               q_x,
  input  logic [15:0]               q_y,
  input  logic [7:0]                q_scale,
  output logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         ch_rst,
  output logic [NUM_CH*ID_W-1:0]    ch_id,
  output logic [NUM_CH*COORD_W-1:0] ch_x,
  output logic [NUM_CH*COORD_W-1:0] ch_y,
  output logic [NUM_CH*8-1:0]       ch_scale,
  input  logic [NUM_CH-1:0]         ch_finished,
  output logic                      frame_idle,
  output logic [CNT_W-1:0]          dispatch_cnt,
  output logic [CNT_W-1:0]          cull_cnt
);

  localparam int          IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] X_LIM = 16'(FB_WIDTH);
  localparam logic [15:0] Y_LIM = 16'(FB_HEIGHT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] fix_scale(input logic [7:0] s);
    return (s == 8'd0) ? 8'd1 : s;
  endfunction

  logic [NUM_CH-1:0]         ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]         ch_rst_q, ch_rst_d;
  logic [NUM_CH*ID_W-1:0]    ch_id_q, ch_id_d;
  logic [NUM_CH*COORD_W-1:0] ch_x_q, ch_x_d;
  logic [NUM_CH*COORD_W-1:0] ch_y_q, ch_y_d;
  logic [NUM_CH*8-1:0]       ch_scale_q, ch_scale_d;
  logic                      q_dequeue_q, q_dequeue_d;
  logic                      frame_idle_q, frame_idle_d;
  logic [CNT_W-1:0]          dispatch_cnt_q, dispatch_cnt_d;
  logic [CNT_W-1:0]          cull_cnt_q, cull_cnt_d;

  logic [NUM_CH-1:0]         finish;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [IDX_W-1:0]          cand;
  logic                      culled;
  logic                      pop;

`ifdef SPRITE_DISPATCH_RR_EN
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
`endif

  // Channel selection: only channels idle at the start of this cycle are
  // candidates, so a channel freed on this edge waits one more cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef SPRITE_DISPATCH_RR_EN
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CH);
`else
      cand = IDX_W'(k);
`endif
      if (!sel_found && !ch_en_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state: finishes, pop/cull/dispatch, statistics, frame_idle.
  always_comb begin
    ch_en_d        = ch_en_q;
    ch_rst_d       = ch_rst_q;
    ch_id_d        = ch_id_q;
    ch_x_d         = ch_x_q;
    ch_y_d         = ch_y_q;
    ch_scale_d     = ch_scale_q;
    q_dequeue_d    = 1'b0;
    dispatch_cnt_d = dispatch_cnt_q;
    cull_cnt_d     = cull_cnt_q;
`ifdef SPRITE_DISPATCH_RR_EN
    rr_ptr_d       = rr_ptr_q;
`endif

    // finished is only honoured on busy channels
    finish   = ch_en_q & ch_finished;
    ch_en_d  = ch_en_q & ~finish;
    ch_rst_d = ch_rst_q | finish;

    culled = (q_x >= X_LIM) || (q_y >= Y_LIM);
    // the cycle after a pop the queue head is still updating, so skip it
    pop    = !q_is_empty && !q_dequeue_q && sel_found;

    if (pop) begin
      q_dequeue_d = 1'b1;
      if (culled) begin
        cull_cnt_d = sat_inc(cull_cnt_q);
      end else begin
        ch_en_d[sel_idx]  = 1'b1;
        ch_rst_d[sel_idx] = 1'b0;
        ch_id_d[int'(sel_idx)*ID_W +: ID_W]       = q_id[ID_W-1:0];
        ch_x_d[int'(sel_idx)*COORD_W +: COORD_W]  = q_x[COORD_W-1:0];
        ch_y_d[int'(sel_idx)*COORD_W +: COORD_W]  = q_y[COORD_W-1:0];
        ch_scale_d[int'(sel_idx)*8 +: 8]          = fix_scale(q_scale);
        dispatch_cnt_d = sat_inc(dispatch_cnt_q);
`ifdef SPRITE_DISPATCH_RR_EN
        rr_ptr_d = IDX_W'((int'(sel_idx) + 1) % NUM_CH);
`endif
      end
    end

    frame_idle_d = q_is_empty && !q_dequeue_q && !(|ch_en_q);
  end

  // State register stage
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      ch_en_q        <= '0;
      ch_rst_q       <= '1;
      ch_id_q        <= '0;
      ch_x_q         <= '0;
      ch_y_q         <= '0;
      ch_scale_q     <= '0;
      q_dequeue_q    <= 1'b0;
      frame_idle_q   <= 1'b0;
      dispatch_cnt_q <= '0;
      cull_cnt_q     <= '0;
`ifdef SPRITE_DISPATCH_RR_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      ch_en_q        <= ch_en_d;
      ch_rst_q       <= ch_rst_d;
      ch_id_q        <= ch_id_d;
      ch_x_q         <= ch_x_d;
      ch_y_q         <= ch_y_d;
      ch_scale_q     <= ch_scale_d;
      q_dequeue_q    <= q_dequeue_d;
      frame_idle_q   <= frame_idle_d;
      dispatch_cnt_q <= dispatch_cnt_d;
      cull_cnt_q     <= cull_cnt_d;
`ifdef SPRITE_DISPATCH_RR_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  assign q_dequeue    = q_dequeue_q;
  assign ch_en        = ch_en_q;
  assign ch_rst       = ch_rst_q;
  assign ch_id        = ch_id_q;
  assign ch_x         = ch_x_q;
  assign ch_y         = ch_y_q;
  assign ch_scale     = ch_scale_q;
  assign frame_idle   = frame_idle_q;
  assign dispatch_cnt = dispatch_cnt_q;
  assign cull_cnt     = cull_cnt_q;

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Bench for sprite_dispatcher: directed scenarios followed by random traffic,
// all checked against a command-level reference model. A second instance with
// 3-bit counters shares the stimulus so counter saturation is reachable.
module tb_sprite_dispatcher;

  localparam int NUM_CH    = 4;
  localparam int ID_W      = 8;
  localparam int COORD_W   = 10;
  localparam int FB_WIDTH  = 800;
  localparam int FB_HEIGHT = 600;
  localparam int CNT_W     = 16;
  localparam int CNT_S     = 3;

  typedef struct {
    int id;
    int x;
    int y;
    int sc;
  } cmd_t;

  logic                      clock;
  logic                      fb_resetting;
  logic                      q_is_empty;
  logic [7:0]                q_id;
  logic [15:0]               q_x;
  logic [15:0]               q_y;
  logic [7:0]                q_scale;
  logic [NUM_CH-1:0]         ch_finished;

  logic                      q_dequeue;
  logic [NUM_CH-1:0]         ch_en, ch_rst;
  logic [NUM_CH*ID_W-1:0]    ch_id;
  logic [NUM_CH*COORD_W-1:0] ch_x, ch_y;
  logic [NUM_CH*8-1:0]       ch_scale;
  logic                      frame_idle;
  logic [CNT_W-1:0]          dispatch_cnt, cull_cnt;

  logic                      q_dequeue_s;
  logic [NUM_CH-1:0]         ch_en_s, ch_rst_s;
  logic [NUM_CH*ID_W-1:0]    ch_id_s;
  logic [NUM_CH*COORD_W-1:0] ch_x_s, ch_y_s;
  logic [NUM_CH*8-1:0]       ch_scale_s;
  logic                      frame_idle_s;
  logic [CNT_S-1:0]          dispatch_cnt_s, cull_cnt_s;

  sprite_dispatcher #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .COORD_W(COORD_W),
    .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .fb_resetting(fb_resetting), .q_dequeue(q_dequeue),
    .q_is_empty(q_is_empty), .q_id(q_id), .q_x(q_x), .q_y(q_y),
    .q_scale(q_scale), .ch_en(ch_en), .ch_rst(ch_rst), .ch_id(ch_id),
    .ch_x(ch_x), .ch_y(ch_y), .ch_scale(ch_scale), .ch_finished(ch_finished),
    .frame_idle(frame_idle), .dispatch_cnt(dispatch_cnt), .cull_cnt(cull_cnt)
  );

  sprite_dispatcher #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .COORD_W(COORD_W),
    .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .CNT_W(CNT_S)
  ) dut_s (
    .clock(clock), .fb_resetting(fb_resetting), .q_dequeue(q_dequeue_s),
    .q_is_empty(q_is_empty), .q_id(q_id), .q_x(q_x), .q_y(q_y),
    .q_scale(q_scale), .ch_en(ch_en_s), .ch_rst(ch_rst_s), .ch_id(ch_id_s),
    .ch_x(ch_x_s), .ch_y(ch_y_s), .ch_scale(ch_scale_s),
    .ch_finished(ch_finished), .frame_idle(frame_idle_s),
    .dispatch_cnt(dispatch_cnt_s), .cull_cnt(cull_cnt_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // queue contents presented to the DUT
  cmd_t cmd_q[$];

  // reference model: which channels hold which sprite, plus totals
  logic [NUM_CH-1:0] m_busy, m_rst;
  int  m_id[NUM_CH];
  int  m_x[NUM_CH];
  int  m_y[NUM_CH];
  int  m_sc[NUM_CH];
  bit  m_deq, m_idle;
  int  m_disp, m_cull, m_ptr;

  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_busy = '0;
    m_rst  = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_id[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sc[i] = 0;
    end
    m_deq = 0; m_idle = 0; m_disp = 0; m_cull = 0; m_ptr = 0;
  endtask

  function automatic int pick_channel();
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
`ifdef SPRITE_DISPATCH_RR_EN
      c = (m_ptr + k) % NUM_CH;
`else
      c = k;
`endif
      if (!m_busy[c]) return c;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs now on the pins.
  task automatic model_step();
    int   sel;
    bit   pop, nxt_idle;
    cmd_t h;
    sel      = pick_channel();
    nxt_idle = q_is_empty && !m_deq && (m_busy == '0);
    pop      = !q_is_empty && !m_deq && (sel >= 0);
    for (int i = 0; i < NUM_CH; i++)
      if (m_busy[i] && ch_finished[i]) begin
        m_busy[i] = 1'b0;
        m_rst[i]  = 1'b1;
      end
    if (pop) begin
      h = cmd_q[0];
      if (h.x >= FB_WIDTH || h.y >= FB_HEIGHT) begin
        m_cull++;
      end else begin
        m_busy[sel] = 1'b1;
        m_rst[sel]  = 1'b0;
        m_id[sel]   = h.id;
        m_x[sel]    = h.x;
        m_y[sel]    = h.y;
        m_sc[sel]   = (h.sc == 0) ? 1 : h.sc;
        m_disp++;
        m_ptr = (sel + 1) % NUM_CH;
      end
    end
    m_deq  = pop;
    m_idle = nxt_idle;
  endtask

  task automatic compare_all();
    logic [NUM_CH*ID_W-1:0]    e_id;
    logic [NUM_CH*COORD_W-1:0] e_x, e_y;
    logic [NUM_CH*8-1:0]       e_sc;
    for (int i = 0; i < NUM_CH; i++) begin
      e_id[i*ID_W +: ID_W]       = ID_W'(m_id[i]);
      e_x[i*COORD_W +: COORD_W]  = COORD_W'(m_x[i]);
      e_y[i*COORD_W +: COORD_W]  = COORD_W'(m_y[i]);
      e_sc[i*8 +: 8]             = 8'(m_sc[i]);
    end
    check("q_dequeue", 64'(q_dequeue), 64'(m_deq));
    check("ch_en", 64'(ch_en), 64'(m_busy));
    check("ch_rst", 64'(ch_rst), 64'(m_rst));
    check("ch_id", 64'(ch_id), 64'(e_id));
    check("ch_x", 64'(ch_x), 64'(e_x));
    check("ch_y", 64'(ch_y), 64'(e_y));
    check("ch_scale", 64'(ch_scale), 64'(e_sc));
    check("frame_idle", 64'(frame_idle), 64'(m_idle));
    check("dispatch_cnt", 64'(dispatch_cnt), 64'(sat(m_disp, CNT_W)));
    check("cull_cnt", 64'(cull_cnt), 64'(sat(m_cull, CNT_W)));
    check("dispatch_cnt_sat", 64'(dispatch_cnt_s), 64'(sat(m_disp, CNT_S)));
    check("cull_cnt_sat", 64'(cull_cnt_s), 64'(sat(m_cull, CNT_S)));
  endtask

  task automatic apply_drive();
    q_is_empty = (cmd_q.size() == 0);
    if (cmd_q.size() != 0) begin
      q_id    = 8'(cmd_q[0].id);
      q_x     = 16'(cmd_q[0].x);
      q_y     = 16'(cmd_q[0].y);
      q_scale = 8'(cmd_q[0].sc);
    end else begin
      q_id = '0; q_x = '0; q_y = '0; q_scale = '0;
    end
  endtask

  task automatic push(input int id, input int x, input int y, input int sc);
    cmd_t c;
    c.id = id; c.x = x; c.y = y; c.sc = sc;
    cmd_q.push_back(c);
    apply_drive();
  endtask

  // One clock: the queue pops on the edge where q_dequeue is high.
  task automatic cycle();
    bit deq_seen;
    deq_seen = q_dequeue;
    model_step();
    @(posedge clock);
    #1;
    if (deq_seen && cmd_q.size() != 0) void'(cmd_q.pop_front());
    apply_drive();
    compare_all();
  endtask

  task automatic do_reset();
    fb_resetting = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    cmd_q.delete();
    ch_finished = '0;
    apply_drive();
    fb_resetting = 1'b0;
    compare_all();
  endtask

  int pops;
  int order[$];
  int exp_order[5];

  initial begin
    fb_resetting = 1'b0;
    ch_finished  = '0;
    apply_drive();
    #1;

    // single command to an empty dispatcher
    do_reset();
    push(5, 100, 50, 3);
    cycle();
    check("t1_deq", 64'(q_dequeue), 64'(1));
    check("t1_en", 64'(ch_en), 64'(4'b0001));
    check("t1_id", 64'(ch_id[ID_W-1:0]), 64'(5));
    check("t1_x", 64'(ch_x[COORD_W-1:0]), 64'(100));
    check("t1_y", 64'(ch_y[COORD_W-1:0]), 64'(50));
    check("t1_scale", 64'(ch_scale[7:0]), 64'(3));
    check("t1_dcnt", 64'(dispatch_cnt), 64'(1));
    check("t1_idle", 64'(frame_idle), 64'(0));
    cycle();
    check("t1_deq_once", 64'(q_dequeue), 64'(0));
    ch_finished = 4'b0001;
    cycle();
    ch_finished = '0;
    check("t1_freed", 64'(ch_en), 64'(0));
    check("t1_idle_lat0", 64'(frame_idle), 64'(0));
    cycle();
    check("t1_idle_lat1", 64'(frame_idle), 64'(1));

    // six commands, channels never finish
    do_reset();
    for (int i = 0; i < 6; i++) push(10 + i, 20 * i, 30 + i, i + 1);
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (q_dequeue) pops++;
    end
    check("t2_pops", 64'(pops), 64'(4));
    check("t2_all_busy", 64'(ch_en), 64'(4'b1111));
    check("t2_left", 64'(cmd_q.size()), 64'(2));
    ch_finished = 4'b0100;
    cycle();
    ch_finished = '0;
    check("t2_free2_en", 64'(ch_en), 64'(4'b1011));
    check("t2_free2_rst", 64'(ch_rst[2]), 64'(1));
    cycle();
    check("t2_redeq", 64'(q_dequeue), 64'(1));
    check("t2_redisp_en", 64'(ch_en), 64'(4'b1111));
    check("t2_redisp_id", 64'(ch_id[2*ID_W +: ID_W]), 64'(14));

    // culling at both limits, then the last in-bounds pixel with scale 0
    do_reset();
    push(1, 800, 10, 7);
    push(2, 10, 600, 7);
    push(3, 799, 599, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("t3_cull", 64'(cull_cnt), 64'(2));
    check("t3_dcnt", 64'(dispatch_cnt), 64'(0));
    check("t3_en", 64'(ch_en), 64'(0));
    cycle();
    check("t4_en", 64'(ch_en), 64'(4'b0001));
    check("t4_scale", 64'(ch_scale[7:0]), 64'(1));
    check("t4_x", 64'(ch_x[COORD_W-1:0]), 64'(799));
    check("t4_y", 64'(ch_y[COORD_W-1:0]), 64'(599));

    // channel order when every channel finishes immediately
`ifdef SPRITE_DISPATCH_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    ch_finished = '1;
    for (int i = 0; i < 5; i++) push(40 + i, 5 * i, 7 * i, 2);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (q_dequeue)
        for (int k = 0; k < NUM_CH; k++)
          if (ch_en[k]) order.push_back(k);
    end
    ch_finished = '0;
    check("t5_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      check("t5_order", 64'((i < order.size()) ? order[i] : -1), 64'(exp_order[i]));

    // reset while three channels are busy
    do_reset();
    for (int i = 0; i < 3; i++) push(60 + i, 100 + i, 200 + i, 4);
    for (int i = 0; i < 6; i++) cycle();
    check("t6_busy", 64'(ch_en), 64'(4'b0111));
    do_reset();
    check("t6_rst_en", 64'(ch_en), 64'(0));
    check("t6_rst_rst", 64'(ch_rst), 64'(4'b1111));
    check("t6_idle0", 64'(frame_idle), 64'(0));
    cycle();
    check("t6_idle1", 64'(frame_idle), 64'(1));

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (cmd_q.size() < 8 && $urandom_range(0, 2) == 0) begin
        int x, y, sc;
        x  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1023));
        y  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 700));
        sc = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
        push(int'($urandom_range(0, 255)), x, y, sc);
      end
      for (int i = 0; i < NUM_CH; i++) ch_finished[i] = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_dispatcher.md
Name: sprite_dispatcher

Overview:
- Takes sprite draw commands from the sprite draw queue and hands them to NUM_CH sprite_render channels.
- Generalises the fixed two-channel distributor:
  - parametrised channel count and field widths
  - off-screen command culling
  - zero-scale fixup
  - per-frame statistics
  - a frame_idle indication that the framebuffer swap logic uses to know all sprites for the frame are drawn.
- Sits between the sprite queue and the sprite_render instances inside sprite_driver.

Parameters:
- NUM_CH, 4, number of renderer channels (1..8)
- ID_W, 8, sprite id width forwarded to channels
- COORD_W, 10, coordinate width forwarded to channels
- FB_WIDTH, 800, horizontal cull limit in pixels
- FB_HEIGHT, 600, vertical cull limit in pixels
- CNT_W, 16, width of the statistics counters

Ports:
- clock  in  1  system clock
- fb_resetting  in  1  reset, asynchronous, active-high; also clears per-frame state
- q_dequeue  out  1  one-cycle pop strobe to the sprite queue
- q_is_empty  in  1  queue empty flag
- q_id  in  8  head sprite id
- q_x  in  16  head x, unsigned
- q_y  in  16  head y, unsigned
- q_scale  in  8  head scale
- ch_en  out  NUM_CH  per-channel enable
- ch_rst  out  NUM_CH  per-channel renderer reset
- ch_id  out  NUM_CH*ID_W  packed ids; channel i at [i*ID_W +: ID_W]
- ch_x  out  NUM_CH*COORD_W  packed x
- ch_y  out  NUM_CH*COORD_W  packed y
- ch_scale  out  NUM_CH*8  packed scale
- ch_finished  in  NUM_CH  per-channel finished from the renderer
- frame_idle  out  1  queue empty and all channels idle
- dispatch_cnt  out  CNT_W  sprites dispatched since reset
- cull_cnt  out  CNT_W  sprites culled since reset

Behaviour:
- Reset (async, fb_resetting=1):
  - ch_en=0, ch_rst=all ones, ch_id/ch_x/ch_y/ch_scale=0.
  - q_dequeue=0, frame_idle=0, counters=0, RR pointer=0.
- Channel state: each channel is IDLE when ch_en[i]=0 and BUSY when ch_en[i]=1.
  - BUSY->IDLE: when ch_en[i]&&ch_finished[i], the next edge sets ch_en[i]=0 and ch_rst[i]=1.
  - A channel freed on an edge is eligible for dispatch from the following cycle only.
  - ch_finished on an IDLE channel is ignored.
- Pop handshake:
  - A pop is attempted when q_is_empty=0, q_dequeue=0 and at least one channel is IDLE.
  - On the attempt edge: q_dequeue=1 for exactly one cycle.
  - The cycle after a pop never pops (the queue head updates).
  - Maximum throughput is one command per 2 cycles.
- Cull:
  - Condition: q_x>=FB_WIDTH or q_y>=FB_HEIGHT.
  - A culled command is still popped (q_dequeue=1), but no channel changes state and cull_cnt increments.
  - A culled command still requires an IDLE channel to exist; this keeps ordering simple.
- Dispatch (not culled):
  - The selected channel i gets ch_en[i]=1 and ch_rst[i]=0.
  - ch_id[i]=q_id[ID_W-1:0], ch_x[i]=q_x[COORD_W-1:0], ch_y[i]=q_y[COORD_W-1:0].
  - ch_scale[i]=q_scale, except 0 is forced to 1.
  - dispatch_cnt increments.
  - Fields of a BUSY channel are stable until it returns to IDLE.
- Selection: lowest-index IDLE channel (fixed priority); see Optional Feature for the alternative.
- Counters saturate at all ones (no wrap).
- frame_idle:
  - Registered: 1 when q_is_empty=1, q_dequeue=0 and all ch_en=0 on the previous cycle.
  - Latency is 1 cycle after the last channel goes IDLE.
- Simultaneous events:
  - A finish on channel j and a dispatch to channel k≠j on the same edge are both applied.
  - Finishes on several channels on the same edge are all applied.
- Reset mid-operation: all in-flight sprites are abandoned. The queue is not popped during reset.

Optional Feature:
- Macro SPRITE_DISPATCH_RR_EN.
- Defined:
  - Round-robin selection: search IDLE channels starting at the RR pointer, wrapping mod NUM_CH.
  - After a dispatch, pointer = (selected+1) mod NUM_CH. Culls do not move the pointer.
- Undefined: fixed lowest-index priority and no pointer register.

Test Plan:
- Reset, then 1 command (id=5,x=100,y=50,scale=3) -> q_dequeue pulses 1 cycle; ch_en=0001, ch_x[0]=100, ch_y[0]=50, ch_scale[0]=3, dispatch_cnt=1; frame_idle=0.
- 6 queued commands, channels never finish, NUM_CH=4 -> exactly 4 pops on alternate cycles; ch_en=1111; then no q_dequeue while q_is_empty=0. Assert ch_finished[2] -> ch_en[2]=0, ch_rst[2]=1; next eligible cycle dispatches command 5 to channel 2.
- Commands x=800,y=10 and x=10,y=600 -> both popped, ch_en unchanged, cull_cnt=2, dispatch_cnt=0.
- scale=0 -> ch_scale[0]=1.
- SPRITE_DISPATCH_RR_EN, all idle, channels finish immediately, 5 commands -> channel order 0,1,2,3,0. Without the macro -> always channel 0.
- Assert fb_resetting while 3 channels are BUSY -> ch_en=0, ch_rst=1111, counters=0 asynchronously; after release with an empty queue, frame_idle=1 one cycle later.
